// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter with a one-word holding buffer.
//
// Serialises parallel words onto a single line: start bit (0), data bits
// MSB first, optional even-parity bit, one or two stop bits (1). A producer
// may queue the next word while the current frame shifts out; queued words
// follow with no idle gap between frames.
//
// Ports:
//   clk    in   master clock, all logic on its rising edge
//   rst    in   synchronous active-high reset
//   data   in   word to transmit, captured on an edge with send & ready
//   send   in   producer request
//   ready  out  holding buffer empty, a word can be accepted this cycle
//   busy   out  a frame is being shifted out (FSM not IDLE)
//   tx     out  serial line, idle high, registered
module uart_tx #(
   parameter int C_CLK_FRQ         = 100_000_000,
   parameter int C_UART_RATE       = 1_000_000,
   parameter int C_UART_DATA_WIDTH = 8,
   parameter int C_UART_PARITY     = 1,
   parameter int C_UART_STOP       = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [C_UART_DATA_WIDTH-1:0] data,
   input  logic                         send,
   output logic                         ready,
   output logic                         busy,
   output logic                         tx
);

   localparam int C_PERIOD = C_CLK_FRQ / C_UART_RATE;
   localparam int CW       = (C_PERIOD > 1) ? $clog2(C_PERIOD) : 1;
   localparam int BW       = $clog2(C_UART_DATA_WIDTH + 2);

   localparam logic [CW-1:0] CYC_LAST  = CW'(C_PERIOD - 1);
   localparam logic [CW-1:0] CYC_ONE   = CW'(1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [BW-1:0] DATA_LAST = BW'(C_UART_DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(C_UART_STOP - 1);

   if ((C_UART_STOP != 1) && (C_UART_STOP != 2)) begin : g_bad_stop
      $error("uart_tx: C_UART_STOP must be 1 or 2");
   end

   if (C_PERIOD < 2) begin : g_bad_period
      $error("uart_tx: C_CLK_FRQ / C_UART_RATE must be at least 2");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [C_UART_DATA_WIDTH-1:0] word);
      even_parity = ^word;
   endfunction

   state_t                         state_r;
   logic [C_UART_DATA_WIDTH-1:0]   buf_r;
   logic                           buf_full_r;
   logic [C_UART_DATA_WIDTH-1:0]   shift_r;
   logic                           parity_r;
   logic [CW-1:0]                  cyc_r;
   logic [BW-1:0]                  bit_r;
   logic                           tx_r;
   logic                           ready_r;
   logic                           busy_r;

   logic                           cyc_last_s;
   logic                           stop_done_s;
   logic                           load_s;
   logic                           accept_s;
   logic [C_UART_DATA_WIDTH-1:0]   shift_next_s;

   assign cyc_last_s   = (cyc_r == CYC_LAST);
   // Last cycle of the last stop bit: the point where a queued word is
   // chained straight into the next start bit.
   assign stop_done_s  = (state_r == STOP) && cyc_last_s && (bit_r == STOP_LAST);
   assign load_s       = buf_full_r && ((state_r == IDLE) || stop_done_s);
   assign accept_s     = send && ready_r;
   assign shift_next_s = shift_r << 1;

   assign tx    = tx_r;
   assign ready = ready_r;
   assign busy  = busy_r;

   // Holding buffer and ready flag; ready tracks the buffer's next state so
   // it drops right after a capture and rises right after a load.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_r      <= '0;
         buf_full_r <= 1'b0;
         ready_r    <= 1'b0;
      end else if (load_s) begin
         buf_full_r <= 1'b0;
         ready_r    <= 1'b1;
      end else if (accept_s) begin
         buf_r      <= data;
         buf_full_r <= 1'b1;
         ready_r    <= 1'b0;
      end else begin
         ready_r    <= ~buf_full_r;
      end
   end

   // Frame FSM: drives tx and busy as registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         shift_r  <= '0;
         parity_r <= 1'b0;
         cyc_r    <= '0;
         bit_r    <= '0;
         tx_r     <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               cyc_r <= '0;
               bit_r <= '0;
               if (load_s) begin
                  shift_r  <= buf_r;
                  parity_r <= even_parity(buf_r);
                  state_r  <= START;
                  tx_r     <= 1'b0;
                  busy_r   <= 1'b1;
               end else begin
                  tx_r     <= 1'b1;
                  busy_r   <= 1'b0;
               end
            end
            START: begin
               if (cyc_last_s) begin
                  cyc_r   <= '0;
                  state_r <= DATA;
                  tx_r    <= shift_r[C_UART_DATA_WIDTH-1];
               end else begin
                  cyc_r   <= cyc_r + CYC_ONE;
               end
            end
            DATA: begin
               if (cyc_last_s) begin
                  cyc_r <= '0;
                  if (bit_r == DATA_LAST) begin
                     bit_r <= '0;
                     if (C_UART_PARITY == 1) begin
                        state_r <= PARITY;
                        tx_r    <= parity_r;
                     end else begin
                        state_r <= STOP;
                        tx_r    <= 1'b1;
                     end
                  end else begin
                     bit_r   <= bit_r + BIT_ONE;
                     shift_r <= shift_next_s;
                     tx_r    <= shift_next_s[C_UART_DATA_WIDTH-1];
                  end
               end else begin
                  cyc_r <= cyc_r + CYC_ONE;
               end
            end
            PARITY: begin
               if (cyc_last_s) begin
                  cyc_r   <= '0;
                  state_r <= STOP;
                  tx_r    <= 1'b1;
               end else begin
                  cyc_r   <= cyc_r + CYC_ONE;
               end
            end
            STOP: begin
               if (cyc_last_s) begin
                  cyc_r <= '0;
                  if (bit_r == STOP_LAST) begin
                     bit_r <= '0;
                     if (load_s) begin
                        shift_r  <= buf_r;
                        parity_r <= even_parity(buf_r);
                        state_r  <= START;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
                     end else begin
                        state_r  <= IDLE;
                        tx_r     <= 1'b1;
                        busy_r   <= 1'b0;
                     end
                  end else begin
                     bit_r <= bit_r + BIT_ONE;
                  end
               end else begin
                  cyc_r <= cyc_r + CYC_ONE;
               end
            end
            default: begin
               state_r <= IDLE;
               cyc_r   <= '0;
               bit_r   <= '0;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx. Expected words go into a queue
// when offered; a line decoder pops them at each start bit and checks every
// sample of the frame. A second instance covers the no-parity, two-stop
// configuration.
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic       send;
   logic       ready;
   logic       busy;
   logic       tx;

   logic [7:0] data2;
   logic       send2;
   logic       ready2;
   logic       busy2;
   logic       tx2;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         rst_count = 0;
   int         frames_started = 0;
   int         frames_done = 0;
   int         start_cyc[$];
   logic [7:0] exp_q[$];

   uart_tx dut (
      .clk(clk), .rst(rst), .data(data), .send(send),
      .ready(ready), .busy(busy), .tx(tx)
   );

   uart_tx #(.C_UART_PARITY(0), .C_UART_STOP(2)) dut2 (
      .clk(clk), .rst(rst), .data(data2), .send(send2),
      .ready(ready2), .busy(busy2), .tx(tx2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rst) rst_count <= rst_count + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with ready high; returns just after the transfer edge.
   task automatic send_word(input logic [7:0] w);
      data = w;
      send = 1'b1;
      @(posedge clk);
      #1;
      send = 1'b0;
      data = 8'($urandom);
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      @(negedge clk);
      while (ready !== 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check(tag, ready, 32'd1);
   endtask

   task automatic wait_frames(input int n, input int budget, input string tag);
      int k = 0;
      while (frames_done < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, frames_done, n);
   endtask

   // Line decoder for the default instance: 100 samples per bit, 11 bits.
   initial begin : monitor
      logic [7:0]  w;
      logic [10:0] bits;
      int          rc;
      int          bad;
      bit          aborted;
      forever begin
         @(negedge clk);
         if (tx === 1'b0 && rst === 1'b0) begin
            start_cyc.push_back(cyc);
            frames_started++;
            rc = rst_count;
            check("frame_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) w = exp_q.pop_front();
            else w = 8'h00;
            bits = {1'b0, w, ^w, 1'b1};
            aborted = 1'b0;
            for (int b = 0; b < 11 && !aborted; b++) begin
               bad = 0;
               for (int c = 0; c < 100; c++) begin
                  if (!(b == 0 && c == 0)) @(negedge clk);
                  if (rst_count != rc) aborted = 1'b1;
                  else if (tx !== bits[10-b] || busy !== 1'b1) bad++;
               end
               if (!aborted)
                  check($sformatf("frame%0d_%02h_bit%0d", frames_started, w, b), bad, 32'd0);
            end
            if (!aborted) frames_done++;
         end
      end
   end

   initial begin : stim
      int cnt;
      int low;
      int bad;
      logic exp_bit;
      logic [7:0] w2;

      rst = 1'b1; send = 1'b0; data = 8'h00; send2 = 1'b0; data2 = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 32'd1);
      check("rst_ready", ready, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_tx2", tx2, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", ready, 32'd1);
      check("busy_after_rst", busy, 32'd0);

      // 0xA5: latency and exact frame length
      exp_q.push_back(8'hA5);
      send_word(8'hA5);
      @(negedge clk);
      check("a5_ready_full", ready, 32'd0);
      check("a5_tx_idle", tx, 32'd1);
      check("a5_busy_idle", busy, 32'd0);
      @(negedge clk);
      check("a5_tx_start", tx, 32'd0);
      check("a5_busy_start", busy, 32'd1);
      check("a5_ready_freed", ready, 32'd1);
      cnt = 1;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         cnt++;
      end
      check("a5_busy_len", cnt, 32'd1100);
      check("a5_tx_idle_after", tx, 32'd1);
      wait_frames(1, 200, "a5_frame_done");

      // 0x07: parity bit 1
      exp_q.push_back(8'h07);
      send_word(8'h07);
      wait_frames(2, 1500, "07_frame_done");

      // 0x11 then 0x22 back-to-back
      @(negedge clk);
      exp_q.push_back(8'h11);
      send_word(8'h11);
      wait_ready("11_ready_again");
      exp_q.push_back(8'h22);
      send_word(8'h22);
      wait_frames(4, 3000, "1122_frames_done");
      check("b2b_start_gap", start_cyc[3] - start_cyc[2], 32'd1100);

      // Buffer full: held send with 0x33 must be ignored
      @(negedge clk);
      exp_q.push_back(8'h44);
      send_word(8'h44);
      wait_ready("44_ready_again");
      exp_q.push_back(8'h55);
      send_word(8'h55);
      @(negedge clk);
      data = 8'h33;
      send = 1'b1;
      cnt = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (ready === 1'b1) cnt++;
      end
      send = 1'b0;
      check("full_ready_low", cnt, 32'd0);
      wait_frames(6, 4000, "4455_frames_done");
      low = 0;
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         if (tx !== 1'b1) low++;
      end
      check("no_33_frame_tx", low, 32'd0);
      check("no_33_frame_count", frames_started, 32'd6);
      check("queue_empty", exp_q.size(), 32'd0);

      // Reset mid-DATA with a word queued
      exp_q.push_back(8'h66);
      send_word(8'h66);
      wait_ready("66_ready_again");
      send_word(8'h77);
      repeat (150) @(negedge clk);
      check("tx_before_rst", tx, 32'd0);
      check("ready_before_rst", ready, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_tx", tx, 32'd1);
      check("midrst_busy", busy, 32'd0);
      check("midrst_ready", ready, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_ready", ready, 32'd1);
      check("postrst_busy", busy, 32'd0);
      low = 0;
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) low++;
      end
      check("postrst_quiet", low, 32'd0);
      check("postrst_frames", frames_started, 32'd7);
      void'(exp_q.pop_front());

      // No parity, two stop bits: 0x80
      w2 = 8'h80;
      data2 = w2;
      send2 = 1'b1;
      @(posedge clk);
      #1;
      send2 = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (tx2 !== 1'b0 && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      check("p0s2_start_latency", cnt, 32'd1);
      bad = 0;
      for (int k = 0; k < 1100; k++) begin
         if (k > 0) @(negedge clk);
         if (k < 100) exp_bit = 1'b0;
         else if (k < 900) exp_bit = w2[8 - (k / 100)];
         else exp_bit = 1'b1;
         if (tx2 !== exp_bit || busy2 !== 1'b1) bad++;
      end
      check("p0s2_frame_samples", bad, 32'd0);
      @(negedge clk);
      check("p0s2_busy_end", busy2, 32'd0);
      check("p0s2_tx_end", tx2, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter. Serialises parallel words onto a single line in the same frame format the team's UART receiver decodes: start bit, data bits MSB first, optional even-parity bit, stop bit(s).
- Sits between on-chip producers (SDAD sample streamer, debug console) and the board TX pin.
- One-word holding buffer, so a producer can queue the next word while the current frame shifts out. Back-to-back frames have zero idle gap.

Parameters:
- C_CLK_FRQ, 100_000_000: input clock frequency [Hz].
- C_UART_RATE, 1_000_000: bit rate [baud]. C_PERIOD = C_CLK_FRQ / C_UART_RATE (integer division) clock cycles per bit. Requires C_PERIOD >= 2.
- C_UART_DATA_WIDTH, 8: data bits per frame, 1..16.
- C_UART_PARITY, 1: 1 = append even-parity bit, 0 = no parity bit.
- C_UART_STOP, 1: stop bits, legal values 1 or 2. Any other value is an elaboration error.

Ports:
- clk  in  1  master clock; all logic on its rising edge.
- rst  in  1  reset.
- data  in  C_UART_DATA_WIDTH  word to transmit; sampled when send & ready.
- send  in  1  producer request; the word transfers on a rising edge with send & ready.
- ready  out  1  holding buffer empty; a word can be accepted this cycle.
- busy  out  1  a frame is being shifted out (FSM not IDLE).
- tx  out  1  serial line, idle high, registered output.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values while rst = 1 and on the first edge after: tx = 1, ready = 0, busy = 0, holding buffer empty, FSM = IDLE, bit and cycle counters = 0.
  - ready rises on the first edge with rst = 0.
  - rst mid-frame aborts the frame: tx = 1 after that edge, and any queued word is discarded.
- Handshake:
  - ready = holding buffer empty and not in reset.
  - Transfer on an edge with send & ready: the buffer captures data and ready is 0 the next cycle.
  - send while ready = 0 is ignored; the word is not captured and no error is raised.
  - data is don't-care when no transfer occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. If the buffer is full, load the shift register from the buffer, compute parity = XOR of all data bits, empty the buffer, go to START.
  - START: tx = 0 for C_PERIOD cycles, then DATA.
  - DATA: tx = current bit, MSB first. Each bit lasts C_PERIOD cycles. After C_UART_DATA_WIDTH bits, go to PARITY if C_UART_PARITY = 1, else STOP.
  - PARITY: tx = parity for C_PERIOD cycles, then STOP. The parity bit makes the total count of ones over data+parity even.
  - STOP: tx = 1 for C_UART_STOP x C_PERIOD cycles. On the final cycle:
    - buffer full: load directly and go to START, so the next start bit begins on the very next cycle (no idle cycle);
    - buffer empty: go to IDLE.
- Latency: transfer at edge N with FSM in IDLE gives buffer full after edge N, and tx = 0 after edge N+1.
- Frame length: (1 + C_UART_DATA_WIDTH + C_UART_PARITY + C_UART_STOP) x C_PERIOD cycles, exact, with no jitter between bits.
- Buffer and ready timing:
  - The buffer frees on the same edge the FSM loads it; ready rises one cycle after that load edge.
  - The buffer can be refilled at any point during the frame.
- busy = 1 in every state except IDLE. busy stays 1 across back-to-back frames.
- Counters:
  - Cycle counter width $clog2(C_PERIOD); it wraps at C_PERIOD-1 and never overflows.
  - Bit counter width $clog2(C_UART_DATA_WIDTH + 2).

Test Plan:
- Default parameters (C_PERIOD = 100), send 0xA5 once -> tx low 100 cycles, then 1,0,1,0,0,1,0,1 at 100 cycles each, parity 0, stop 1. busy high for 1100 cycles, then tx idles high.
- Send 0x07 -> parity bit = 1 (three ones). Loop tx into UART receiver with matching parameters -> valid with data = 0x07, error = 0.
- Send 0x11 and 0x22 back-to-back (second word offered while ready rises during the first frame) -> second start bit falls on the cycle right after the first stop bit ends. busy never drops; receiver gets 0x11 then 0x22.
- While the buffer is full, hold send = 1 with 0x33 -> ignored; after the current frames only the buffered word is transmitted.
- Assert rst for 1 cycle mid-way through the DATA state with a word queued -> tx = 1 after that edge, busy = 0, no further frame. ready = 1 one cycle after rst falls.
- C_UART_PARITY = 0, C_UART_STOP = 2, send 0x80 -> 0, 1, seven 0s, then 200 cycles high. Total 1100 cycles.
